best_hop_selector: RTL and testbench
====================================

# best_hop_selector

Parametrised next-hop selector for the EER-RL routing core. On `start` it scans the node's neighbor table in shared data memory, fetching ID, hop count and Q-value for each entry. It picks the best next hop: highest Q-value at or above `mybestQ`, otherwise the closest neighbor within `mybestH`. It writes the winner back to memory, publishes it on output ports, and pulses `done`.

## Interface
Parameters:
- `WORD_WIDTH`, 16, data word width.
- `ADDR_WIDTH`, 11, memory address width (byte address; one word = 2 addresses).
- `MAX_NEIGHBORS`, 32, neighbor-table capacity; the fetched count is clamped to this.
- `CNT_ADDR`, 11'h2C4, address of neighborCount.
- `ID_BASE`, 11'h072, first neighborID.
- `HOP_BASE`, 11'h132, first neighborHops.
- `Q_BASE`, 11'h172, first neighborQValue.
- `RES_BASE`, 11'h2F8, result block: besthop at +0, bestneighborID at +2, bestQValue at +4.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a scan; sampled only in IDLE.
- `mybestQ` in WORD_WIDTH: Q threshold; sampled at start.
- `mybestH` in WORD_WIDTH: hop threshold; sampled at start.
- `data_in` in WORD_WIDTH: memory read data, valid one cycle after `address`.
- `address` out ADDR_WIDTH: memory address.
- `data_out` out WORD_WIDTH: memory write data.
- `wr_en` out 1: memory write strobe.
- `busy` out 1: high from the cycle after start until `done`.
- `done` out 1: one-cycle completion pulse.
- `found` out 1: a qualifying neighbor was selected.
- `besthop`, `bestneighborID`, `bestQValue` out WORD_WIDTH each: selection result, held until the next start.

## Operation
- States: IDLE, FETCH_CNT, GET_ID, GET_H, GET_Q, EVAL, WR_HOP, WR_ID, WR_Q, DONE.
- IDLE + start:
  - latch the thresholds;
  - clear candidate registers, `found`, and index n;
  - set `address`=CNT_ADDR; go to FETCH_CNT.
- FETCH_CNT:
  - count = min(data_in, MAX_NEIGHBORS);
  - if count=0, go to WR_HOP; else `address`=ID_BASE+2n and go to GET_ID.
- GET_ID/GET_H/GET_Q: each captures `data_in` and issues the next address (HOP_BASE+2n, then Q_BASE+2n).
- EVAL: classify the entry:
  - best class: Q ≥ mybestQ;
  - close class: hops ≤ mybestH;
  - a best-class entry always beats a close-class incumbent.
- Within best class:
  - higher Q wins;
  - on equal Q, fewer hops wins;
  - on full tie, the incumbent stays unless the tiebreak (see Configuration) replaces it.
- Within close class:
  - fewer hops wins;
  - on equal hops, higher Q wins;
  - on full tie, the incumbent stays.
- Entries in neither class are discarded.
- EVAL then increments n. If n=count go to WR_HOP; else issue ID_BASE+2n and go to GET_ID.
- WR_HOP/WR_ID/WR_Q write besthop, ID and Q to RES_BASE+0/+2/+4 with `wr_en`=1. If `found`=0, the written values are all zero.
- DONE: `done`=1 for one cycle; update the output ports; return to IDLE.
- All comparisons are unsigned. Address arithmetic wraps modulo 2^ADDR_WIDTH.

## Timing
- Reset values: `address`=0, `data_out`=0, `wr_en`=0, `busy`=0, `done`=0, `found`=0, result outputs 0; state IDLE.
- With start sampled in cycle 0 and N = clamped count:
  - each neighbor takes 4 cycles;
  - writes occur in cycles 2+4N … 4+4N;
  - `done` is high in cycle 5+4N.
- Total latency is 5+4N cycles; N=0 gives 5.
- `start` is ignored while busy.
- `start` is accepted again in the cycle after `done`.
- `wr_en` is high only in the WR_* states.
- Reset mid-scan: return to IDLE next cycle with all outputs at reset values; no partial write completes.
- Thresholds changing during a scan have no effect.

## Configuration
- `BEST_HOP_RANDOM_TIEBREAK_EN` defined:
  - instantiate a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset), advancing every cycle;
  - on a best-class full tie, the challenger replaces the incumbent when lfsr[0]=1.
- Undefined: no LFSR; a full tie always keeps the lowest-index entry.
- Close-class tie handling is identical in both builds.

## Structure
- The shared package `eer_rl_pkg` holds:
  - state encoding;
  - default memory map constants (CNT_ADDR, ID_BASE, HOP_BASE, Q_BASE, RES_BASE);
  - WORD_WIDTH/ADDR_WIDTH defaults.
- One sub-module: `lfsr16`, instantiated only under the macro.

## Test plan
- Count=3, Q={10,40,40}, hops={2,5,3}, mybestQ=30, mybestH=4 → index 2 selected, bestQValue=40, besthop=3, found=1, `done` at cycle 17.
- Count=2, Q={5,8} < mybestQ=20, hops={6,2}, mybestH=3 → close class, besthop=2, bestQValue=8, found=1.
- Count=0 → writes zeros to RES_BASE…+4, found=0, `done` at cycle 5.
- Count=40 with MAX_NEIGHBORS=32 → exactly 32 entries read; `done` at cycle 133.
- Reset asserted in the 2nd GET_Q → next cycle IDLE, `wr_en` never asserted, outputs 0. A fresh start then completes normally.
- Full tie of two best entries (Q=50, hops=2):
  - macro off → lower index chosen;
  - macro on with seeded LFSR → result matches the reference-model LFSR bit.

Source files
------------

// File: rtl/eer_rl_pkg.sv
// eer_rl_pkg: shared definitions for the EER-RL routing core.
//   - default datapath widths
//   - default data-memory map (neighbor table and result block)
//   - best_hop_selector FSM state encoding
package eer_rl_pkg;

  localparam int DEF_WORD_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 11;

  // Byte addresses; one 16-bit word spans two addresses.
  localparam logic [10:0] DEF_CNT_ADDR = 11'h2C4;
  localparam logic [10:0] DEF_ID_BASE  = 11'h072;
  localparam logic [10:0] DEF_HOP_BASE = 11'h132;
  localparam logic [10:0] DEF_Q_BASE   = 11'h172;
  localparam logic [10:0] DEF_RES_BASE = 11'h2F8;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH_CNT = 4'd1;
  localparam logic [3:0] S_GET_ID    = 4'd2;
  localparam logic [3:0] S_GET_H     = 4'd3;
  localparam logic [3:0] S_GET_Q     = 4'd4;
  localparam logic [3:0] S_EVAL      = 4'd5;
  localparam logic [3:0] S_WR_HOP    = 4'd6;
  localparam logic [3:0] S_WR_ID     = 4'd7;
  localparam logic [3:0] S_WR_Q      = 4'd8;
  localparam logic [3:0] S_DONE      = 4'd9;

endpackage

// File: rtl/best_hop_selector_if.sv
// best_hop_selector_if: shared data-memory port.
//   address  : byte address driven by the requester
//   data_out : write data driven by the requester
//   wr_en    : write strobe driven by the requester
//   data_in  : read data from memory, valid the cycle after address is presented
// Modports: master (requester side), slave (memory side).
interface best_hop_selector_if #(
  parameter int AW = 11,
  parameter int DW = 16
) ();
  logic [AW-1:0] address;
  logic [DW-1:0] data_out;
  logic          wr_en;
  logic [DW-1:0] data_in;

  modport master (output address, output data_out, output wr_en, input data_in);
  modport slave  (input address, input data_out, input wr_en, output data_in);
endinterface

// File: rtl/best_hop_selector_lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1,
// seeded with 16'hACE1 on reset and advanced every clock.
// Only built when BEST_HOP_RANDOM_TIEBREAK_EN is defined.
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   lsb   : bit 0 of the current LFSR state
module lfsr16 (
  input  logic clock,
  input  logic reset,
  output logic lsb
);
  logic [15:0] state;

  // Right-shifting form: taps 16,14,13,11 map to state bits 0,2,3,5.
  always_ff @(posedge clock) begin
    if (reset) state <= 16'hACE1;
    else       state <= {state[0] ^ state[2] ^ state[3] ^ state[5], state[15:1]};
  end

  assign lsb = state[0];
endmodule

// File: rtl/best_hop_selector.sv
// best_hop_selector: scans the neighbor table in shared memory and picks the
// best next hop. Best class (Q >= mybestQ) ranks by higher Q then fewer hops;
// otherwise close class (hops <= mybestH) ranks by fewer hops then higher Q.
// The winner is written to RES_BASE+0/+2/+4 and published on the result ports.
// Optional macro BEST_HOP_RANDOM_TIEBREAK_EN: best-class full ties are broken
// by an LFSR bit instead of keeping the lowest-index entry.
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   start               : begin a scan (sampled only when idle)
//   mybestQ, mybestH    : thresholds, latched at start
//   mem                 : memory port (address/data_out/wr_en out, data_in in)
//   busy, done          : scan in progress / one-cycle completion pulse
//   found               : a qualifying neighbor was selected
//   besthop, bestneighborID, bestQValue : result, held until next completion
module best_hop_selector
  import eer_rl_pkg::*;
#(
  parameter int                    WORD_WIDTH    = DEF_WORD_WIDTH,
  parameter int                    ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int                    MAX_NEIGHBORS = 32,
  parameter logic [ADDR_WIDTH-1:0] CNT_ADDR      = ADDR_WIDTH'(DEF_CNT_ADDR),
  parameter logic [ADDR_WIDTH-1:0] ID_BASE       = ADDR_WIDTH'(DEF_ID_BASE),
  parameter logic [ADDR_WIDTH-1:0] HOP_BASE      = ADDR_WIDTH'(DEF_HOP_BASE),
  parameter logic [ADDR_WIDTH-1:0] Q_BASE        = ADDR_WIDTH'(DEF_Q_BASE),
  parameter logic [ADDR_WIDTH-1:0] RES_BASE      = ADDR_WIDTH'(DEF_RES_BASE)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] mybestQ,
  input  logic [WORD_WIDTH-1:0] mybestH,
  best_hop_selector_if.master   mem,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [WORD_WIDTH-1:0] besthop,
  output logic [WORD_WIDTH-1:0] bestneighborID,
  output logic [WORD_WIDTH-1:0] bestQValue
);
  localparam int IDX_W = $clog2(MAX_NEIGHBORS + 1);

  logic [3:0]            state;
  logic [WORD_WIDTH-1:0] thr_q, thr_h;
  logic [IDX_W-1:0]      cnt, idx, idx_nxt, cnt_clamp;
  logic [WORD_WIDTH-1:0] cur_id, cur_h, cur_q;
  logic [WORD_WIDTH-1:0] cand_id, cand_h, cand_q;
  logic                  cand_best;
  logic                  ent_best, ent_close, take, tie_swap;

  function automatic logic [ADDR_WIDTH-1:0] ent_addr(input logic [ADDR_WIDTH-1:0] base,
                                                     input logic [IDX_W-1:0]      i);
    return base + (ADDR_WIDTH'(i) << 1);
  endfunction

`ifdef BEST_HOP_RANDOM_TIEBREAK_EN
  lfsr16 u_lfsr (
    .clock (clock),
    .reset (reset),
    .lsb   (tie_swap)
  );
`else
  // Without the LFSR a full tie never displaces the earlier entry.
  assign tie_swap = 1'b0;
`endif

  assign idx_nxt   = idx + IDX_W'(1);
  assign cnt_clamp = (mem.data_in > WORD_WIDTH'(MAX_NEIGHBORS)) ? IDX_W'(MAX_NEIGHBORS)
                                                                 : IDX_W'(mem.data_in);

  // Does the entry just fetched displace the current candidate?
  always_comb begin
    ent_best  = (cur_q >= thr_q);
    ent_close = (cur_h <= thr_h);
    take      = 1'b0;
    if (ent_best) begin
      if (!found || !cand_best)  take = 1'b1;
      else if (cur_q != cand_q)  take = (cur_q > cand_q);
      else if (cur_h != cand_h)  take = (cur_h < cand_h);
      else                       take = tie_swap;
    end else if (ent_close) begin
      // A close-class entry can never displace a best-class incumbent.
      if (!found)                take = 1'b1;
      else if (!cand_best) begin
        if (cur_h != cand_h)     take = (cur_h < cand_h);
        else                     take = (cur_q > cand_q);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      mem.address    <= '0;
      mem.data_out   <= '0;
      mem.wr_en      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      found          <= 1'b0;
      besthop        <= '0;
      bestneighborID <= '0;
      bestQValue     <= '0;
      thr_q          <= '0;
      thr_h          <= '0;
      cnt            <= '0;
      idx            <= '0;
      cur_id         <= '0;
      cur_h          <= '0;
      cur_q          <= '0;
      cand_id        <= '0;
      cand_h         <= '0;
      cand_q         <= '0;
      cand_best      <= 1'b0;
    end else begin
      done      <= 1'b0;
      mem.wr_en <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          thr_q       <= mybestQ;
          thr_h       <= mybestH;
          cand_id     <= '0;
          cand_h      <= '0;
          cand_q      <= '0;
          cand_best   <= 1'b0;
          found       <= 1'b0;
          idx         <= '0;
          busy        <= 1'b1;
          mem.address <= CNT_ADDR;
          state       <= S_FETCH_CNT;
        end
        S_FETCH_CNT: begin
          cnt <= cnt_clamp;
          if (cnt_clamp == '0) begin
            // Empty table: found is already clear, so the result is zero.
            mem.address  <= RES_BASE;
            mem.data_out <= '0;
            mem.wr_en    <= 1'b1;
            state        <= S_WR_HOP;
          end else begin
            mem.address <= ent_addr(ID_BASE, idx);
            state       <= S_GET_ID;
          end
        end
        S_GET_ID: begin
          cur_id      <= mem.data_in;
          mem.address <= ent_addr(HOP_BASE, idx);
          state       <= S_GET_H;
        end
        S_GET_H: begin
          cur_h       <= mem.data_in;
          mem.address <= ent_addr(Q_BASE, idx);
          state       <= S_GET_Q;
        end
        S_GET_Q: begin
          cur_q <= mem.data_in;
          state <= S_EVAL;
        end
        S_EVAL: begin
          if (take) begin
            cand_id   <= cur_id;
            cand_h    <= cur_h;
            cand_q    <= cur_q;
            cand_best <= ent_best;
            found     <= 1'b1;
          end
          idx <= idx_nxt;
          if (idx_nxt == cnt) begin
            // First write uses this cycle's post-evaluation winner.
            mem.address  <= RES_BASE;
            mem.data_out <= take ? cur_h : (found ? cand_h : '0);
            mem.wr_en    <= 1'b1;
            state        <= S_WR_HOP;
          end else begin
            mem.address <= ent_addr(ID_BASE, idx_nxt);
            state       <= S_GET_ID;
          end
        end
        S_WR_HOP: begin
          mem.address  <= RES_BASE + ADDR_WIDTH'(2);
          mem.data_out <= found ? cand_id : '0;
          mem.wr_en    <= 1'b1;
          state        <= S_WR_ID;
        end
        S_WR_ID: begin
          mem.address  <= RES_BASE + ADDR_WIDTH'(4);
          mem.data_out <= found ? cand_q : '0;
          mem.wr_en    <= 1'b1;
          state        <= S_WR_Q;
        end
        S_WR_Q: begin
          // Results become visible together with the done pulse.
          besthop        <= found ? cand_h  : '0;
          bestneighborID <= found ? cand_id : '0;
          bestQValue     <= found ? cand_q  : '0;
          done           <= 1'b1;
          state          <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_best_hop_selector.sv
`timescale 1ns/1ps
module tb_best_hop_selector;
  localparam int          MAXN  = 32;
  localparam logic [10:0] CNT_A = 11'h2C4;
  localparam logic [10:0] ID_A  = 11'h072;
  localparam logic [10:0] HOP_A = 11'h132;
  localparam logic [10:0] Q_A   = 11'h172;
  localparam logic [10:0] RES_A = 11'h2F8;

  typedef struct {
    int          lat;
    int          start_edge;
    logic        found;
    logic [15:0] h, id, q;
  } exp_t;
  typedef struct {
    logic [10:0] a;
    logic [15:0] d;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] mybestQ = '0, mybestH = '0;
  logic        busy, done, found;
  logic [15:0] besthop, bestneighborID, bestQValue;

  logic [15:0] mem [0:1023];
  logic [15:0] t_id [0:39];
  logic [15:0] t_h  [0:39];
  logic [15:0] t_q  [0:39];

  exp_t sb[$];
  wr_t  wq[$];
  int   checks = 0, errors = 0;
  int   ecount = 0;

  best_hop_selector_if #(.AW(11), .DW(16)) bus ();

  best_hop_selector dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .mybestQ        (mybestQ),
    .mybestH        (mybestH),
    .mem            (bus),
    .busy           (busy),
    .done           (done),
    .found          (found),
    .besthop        (besthop),
    .bestneighborID (bestneighborID),
    .bestQValue     (bestQValue)
  );

  always #5 clock = ~clock;
  always @(posedge clock) ecount <= ecount + 1;

  // Asynchronous-read memory: data for the registered address is available
  // within the same cycle, i.e. one edge after the address was issued.
  assign bus.data_in = mem[bus.address[10:1]];

`ifdef BEST_HOP_RANDOM_TIEBREAK_EN
  logic [15:0] tb_lfsr;
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction
  function automatic bit lfsr_bit_at(input logic [15:0] s, input int k);
    logic [15:0] v;
    v = s;
    for (int j = 0; j < k; j++) v = lfsr_step(v);
    return v[0];
  endfunction
  always @(posedge clock) begin
    if (reset) tb_lfsr <= 16'hACE1;
    else       tb_lfsr <= lfsr_step(tb_lfsr);
  end
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: pick from the whole table by ranking rules, not by scanning.
  function automatic exp_t model(input int n, input logic [15:0] tq, input logic [15:0] th);
    exp_t e;
    int   w, bq, bh;
    w = -1; bq = -1; bh = 65536;
    for (int i = 0; i < n; i++)
      if (t_q[i] >= tq && int'(t_q[i]) > bq) bq = int'(t_q[i]);
    if (bq >= 0) begin
      for (int i = 0; i < n; i++)
        if (int'(t_q[i]) == bq && int'(t_h[i]) < bh) bh = int'(t_h[i]);
      for (int i = 0; i < n; i++)
        if (int'(t_q[i]) == bq && int'(t_h[i]) == bh) begin
          if (w < 0) w = i;
`ifdef BEST_HOP_RANDOM_TIEBREAK_EN
          // Entry i is evaluated in cycle 5+4i after the start cycle.
          else if (lfsr_bit_at(tb_lfsr, 5 + 4 * i)) w = i;
`endif
        end
    end else begin
      for (int i = 0; i < n; i++)
        if (t_h[i] <= th && int'(t_h[i]) < bh) bh = int'(t_h[i]);
      for (int i = 0; i < n; i++)
        if (int'(t_h[i]) == bh && int'(t_q[i]) > bq) bq = int'(t_q[i]);
      for (int i = 0; i < n; i++)
        if (w < 0 && int'(t_h[i]) == bh && int'(t_q[i]) == bq) w = i;
    end
    e.lat = 0; e.start_edge = 0;
    e.found = (w >= 0);
    e.h  = (w >= 0) ? t_h[w]  : 16'h0;
    e.id = (w >= 0) ? t_id[w] : 16'h0;
    e.q  = (w >= 0) ? t_q[w]  : 16'h0;
    return e;
  endfunction

  // Monitor: collects writes and checks each completion against the scoreboard.
  always @(negedge clock) begin : mon
    exp_t e;
    logic [15:0] dv;
    if (reset) begin
      wq.delete();
    end else begin
      if (bus.wr_en) begin
        if (sb.size() == 0) check("wr_en_unexpected", 1, 0);
        else wq.push_back('{a: bus.address, d: bus.data_out});
      end
      if (done) begin
        if (sb.size() == 0) check("done_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          check("latency", ecount - e.start_edge + 1, e.lat);
          check("found", found, e.found);
          check("besthop", besthop, e.h);
          check("bestneighborID", bestneighborID, e.id);
          check("bestQValue", bestQValue, e.q);
          check("n_writes", wq.size(), 3);
          for (int k = 0; k < 3 && k < wq.size(); k++) begin
            dv = (k == 0) ? e.h : (k == 1) ? e.id : e.q;
            check("wr_addr", wq[k].a, RES_A + 11'(2 * k));
            check("wr_data", wq[k].d, dv);
          end
          wq.delete();
        end
      end
    end
  end

  task automatic load_mem(input int cnt_word, input int n);
    mem[int'(CNT_A >> 1)] = 16'(cnt_word);
    for (int i = 0; i < n; i++) begin
      mem[int'(ID_A >> 1) + i]  = t_id[i];
      mem[int'(HOP_A >> 1) + i] = t_h[i];
      mem[int'(Q_A >> 1) + i]   = t_q[i];
    end
  endtask

  task automatic do_scan(input int cnt_word, input logic [15:0] tq, input logic [15:0] th,
                         input bit poke);
    exp_t e;
    int   n, k;
    n = (cnt_word > MAXN) ? MAXN : cnt_word;
    load_mem(cnt_word, n);
    e = model(n, tq, th);
    e.lat = 5 + 4 * n;
    e.start_edge = ecount + 1;
    sb.push_back(e);
    mybestQ = tq; mybestH = th; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy_in_scan", busy, 1);
    // Thresholds must have been latched at start.
    mybestQ = 16'($urandom_range(0, 15));
    mybestH = 16'($urandom_range(0, 7));
    if (poke) begin
      @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b0;
    end
    k = 0;
    while (!done && k < e.lat + 20) begin
      @(negedge clock);
      k++;
    end
    if (!done) check("done_timeout", 0, 1);
    @(negedge clock);
    check("busy_after_done", busy, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_found"}, found, 0);
    check({tag, "_besthop"}, besthop, 0);
    check({tag, "_bestid"}, bestneighborID, 0);
    check({tag, "_bestq"}, bestQValue, 0);
    check({tag, "_address"}, bus.address, 0);
    check({tag, "_data_out"}, bus.data_out, 0);
    check({tag, "_wr_en"}, bus.wr_en, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_reset_vals("reset");

    // Best class: entries 1 and 2 tie on Q=40, fewer hops picks entry 2.
    t_id[0] = 16'h0101; t_id[1] = 16'h0202; t_id[2] = 16'h0303;
    t_q[0] = 16'd10; t_q[1] = 16'd40; t_q[2] = 16'd40;
    t_h[0] = 16'd2;  t_h[1] = 16'd5;  t_h[2] = 16'd3;
    do_scan(3, 16'd30, 16'd4, 1'b0);
    check("t1_besthop", besthop, 3);
    check("t1_bestq", bestQValue, 40);
    check("t1_id", bestneighborID, 16'h0303);
    check("t1_found", found, 1);

    // Close class fallback.
    t_id[0] = 16'h0A0A; t_id[1] = 16'h0B0B;
    t_q[0] = 16'd5; t_q[1] = 16'd8;
    t_h[0] = 16'd6; t_h[1] = 16'd2;
    do_scan(2, 16'd20, 16'd3, 1'b1);
    check("t2_besthop", besthop, 2);
    check("t2_bestq", bestQValue, 8);
    check("t2_found", found, 1);

    // Empty table.
    do_scan(0, 16'd1, 16'd1, 1'b0);
    check("t3_found", found, 0);
    check("t3_besthop", besthop, 0);

    // Count above capacity is clamped.
    for (int i = 0; i < 40; i++) begin
      t_id[i] = 16'($urandom); t_q[i] = 16'($urandom_range(0, 60)); t_h[i] = 16'($urandom_range(0, 9));
    end
    do_scan(40, 16'd30, 16'd4, 1'b0);

    // Reset during the second GET_Q (cycle 8 after start).
    t_id[0] = 16'h1111; t_id[1] = 16'h2222; t_id[2] = 16'h3333;
    t_q[0] = 16'd9; t_q[1] = 16'd9; t_q[2] = 16'd9;
    t_h[0] = 16'd1; t_h[1] = 16'd1; t_h[2] = 16'd1;
    load_mem(3, 3);
    mybestQ = 16'd1; mybestH = 16'd1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_reset_vals("midreset");
    reset = 1'b0;
    @(negedge clock);
    do_scan(3, 16'd5, 16'd1, 1'b0);

    // Full tie of two best-class entries.
    t_id[0] = 16'd7; t_id[1] = 16'd9;
    t_q[0] = 16'd50; t_q[1] = 16'd50;
    t_h[0] = 16'd2;  t_h[1] = 16'd2;
    do_scan(2, 16'd30, 16'd1, 1'b0);
`ifndef BEST_HOP_RANDOM_TIEBREAK_EN
    check("tie_lower_index", bestneighborID, 7);
`endif

    // Randomized scans with narrow value ranges to provoke ties.
    for (int r = 0; r < 40; r++) begin
      int c;
      c = ($urandom_range(0, 7) == 0) ? int'($urandom_range(30, 45)) : int'($urandom_range(0, 8));
      for (int i = 0; i < 40; i++) begin
        t_id[i] = 16'($urandom);
        t_q[i]  = 16'($urandom_range(0, 15));
        t_h[i]  = 16'($urandom_range(0, 7));
      end
      do_scan(c, 16'($urandom_range(0, 15)), 16'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clock);
    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
